// File: rtl/iic_chan_sched_pkg.sv
// Shared types and constants for the I2C channel scheduler.
package iic_chan_sched_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W = 3;
    localparam logic [NUM_CH-1:0] IIC_SEL_IDLE = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StStart,
        StWait,
        StGuard
    } state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/iic_rr_arb.sv
// Combinational 8-way round-robin picker: first set request searching upward
// from last+1 with wrap. The pointer register lives in the parent.
module iic_rr_arb
    import iic_chan_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic              valid,
    output logic [CH_W-1:0]   idx
);

    logic [CH_W-1:0] cand;

    // Scan the eight candidates in priority order; the first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = last + CH_W'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/iic_chan_sched.sv
// Schedules the shared I2C master across eight muxed SCL channels.
// Optional WAIT timeout enabled by macro IIC_CHAN_SCHED_TIMEOUT_EN.
module iic_chan_sched
    import iic_chan_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned GUARD_CYC   = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              xfer_done,
    output logic [NUM_CH-1:0] iic_sel,
    output logic [NUM_CH-1:0] grant,
    output logic              xfer_start,
    output logic              busy,
    output logic              xfer_abort,
    output logic [CH_W-1:0]   timeout_ch
);

    localparam int unsigned CntW = $clog2(max2(max2(SETTLE_CYC, GUARD_CYC), TIMEOUT_CYC) + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [NUM_CH-1:0] sel_q, sel_d;
    logic [NUM_CH-1:0] grant_q, grant_d;

    logic              arb_valid;
    logic [CH_W-1:0]   arb_idx;

`ifdef IIC_CHAN_SCHED_TIMEOUT_EN
    logic [CntW-1:0]   wcnt_q, wcnt_d;
    logic              abort_q, abort_d;
    logic [CH_W-1:0]   tch_q, tch_d;
`endif

    iic_rr_arb u_arb (
        .req   (req),
        .last  (last_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // Next-state logic; every register holds unless a transition says otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
`ifdef IIC_CHAN_SCHED_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        abort_d = 1'b0;
        tch_d   = tch_q;
`endif
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    last_d  = arb_idx;
                    sel_d   = {{(NUM_CH - CH_W){1'b0}}, arb_idx};
                    grant_d = NUM_CH'(1) << arb_idx;
                    cnt_d   = CntW'(SETTLE_CYC - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStart: begin
                state_d = StWait;
`ifdef IIC_CHAN_SCHED_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            StWait: begin
                if (xfer_done) begin
                    grant_d = '0;
                    cnt_d   = CntW'(GUARD_CYC - 1);
                    state_d = StGuard;
`ifdef IIC_CHAN_SCHED_TIMEOUT_EN
                end else if (wcnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    // Expiry behaves like a done, plus the abort report.
                    abort_d = 1'b1;
                    tch_d   = last_q;
                    grant_d = '0;
                    cnt_d   = CntW'(GUARD_CYC - 1);
                    state_d = StGuard;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
`endif
                end
            end
            StGuard: begin
                if (cnt_q == '0) begin
                    sel_d   = IIC_SEL_IDLE;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                sel_d   = IIC_SEL_IDLE;
                state_d = StIdle;
            end
        endcase
    end

    // Scheduler state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            sel_q   <= IIC_SEL_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

`ifdef IIC_CHAN_SCHED_TIMEOUT_EN
    // Timeout counter, abort pulse and sticky timed-out channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            abort_q <= 1'b0;
            tch_q   <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            abort_q <= abort_d;
            tch_q   <= tch_d;
        end
    end

    assign xfer_abort = abort_q;
    assign timeout_ch = tch_q;
`else
    assign xfer_abort = 1'b0;
    assign timeout_ch = '0;
`endif

    assign iic_sel    = sel_q;
    assign grant      = grant_q;
    assign xfer_start = (state_q == StStart);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_iic_chan_sched.sv
// Self-checking bench for iic_chan_sched; expected grant channels are queued
// when requests are driven and popped when the scheduler starts a transfer.
module tb_iic_chan_sched;

    localparam int SETTLE = 16;
    localparam int GUARD  = 8;
    localparam int TO     = 100;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       xfer_done;
    logic [7:0] iic_sel;
    logic [7:0] grant;
    logic       xfer_start;
    logic       busy;
    logic       xfer_abort;
    logic [2:0] timeout_ch;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    iic_chan_sched #(
        .SETTLE_CYC  (SETTLE),
        .GUARD_CYC   (GUARD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .xfer_done  (xfer_done),
        .iic_sel    (iic_sel),
        .grant      (grant),
        .xfer_start (xfer_start),
        .busy       (busy),
        .xfer_abort (xfer_abort),
        .timeout_ch (timeout_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int onehot_idx(input logic [7:0] g);
        int r;
        r = -1;
        if ($onehot(g)) begin
            for (int i = 0; i < 8; i++) if (g[i]) r = i;
        end
        return r;
    endfunction

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -99;
        return exp_q.pop_front();
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        xfer_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for xfer_start, reports the granted channel, returns done after
    // done_dly cycles and waits for IDLE. ok=0 when a bound expires.
    task automatic run_xfer(input int done_dly, output int ch, output bit multi,
                            output bit ok);
        int n;
        ok = 1'b1;
        ch = -1;
        multi = 1'b0;
        n = 0;
        while (xfer_start !== 1'b1 && n < 200) begin
            if (!$onehot0(grant)) multi = 1'b1;
            @(negedge clk);
            n++;
        end
        if (xfer_start !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        ch = onehot_idx(grant);
        repeat (done_dly) @(negedge clk);
        xfer_done = 1'b1;
        @(negedge clk);
        xfer_done = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            if (!$onehot0(grant)) multi = 1'b1;
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (iic_sel !== 8'hFF) begin failures++; $display("FAIL reset_sel: got %h want ff", iic_sel); end
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL reset_grant: got %h want 00", grant); end
        checks++; if ({xfer_start, busy, xfer_abort} !== 3'b000) begin failures++; $display("FAIL reset_ctl: got %b want 000", {xfer_start, busy, xfer_abort}); end
        checks++; if (timeout_ch !== 3'd0) begin failures++; $display("FAIL reset_tch: got %0d want 0", timeout_ch); end
    endtask

    task automatic test_single();
        int n;
        int e;
        do_reset();
        exp_q.push_back(2);
        req = 8'h04;
        @(negedge clk);
        checks++; if (iic_sel !== 8'h02) begin failures++; $display("FAIL single_sel: got %h want 02", iic_sel); end
        checks++; if (grant !== 8'h04) begin failures++; $display("FAIL single_grant: got %h want 04", grant); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        e = pop_exp();
        checks++; if (onehot_idx(grant) !== e) begin failures++; $display("FAIL single_ch: got %0d want %0d", onehot_idx(grant), e); end
        n = 0;
        while (xfer_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n !== SETTLE) begin failures++; $display("FAIL single_settle: got %0d want %0d", n, SETTLE); end
        @(negedge clk);
        checks++; if (xfer_start !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b want 0", xfer_start); end
        repeat (12) @(negedge clk);
        xfer_done = 1'b1;
        @(negedge clk);
        xfer_done = 1'b0;
        req = 8'h00;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL single_grant_clr: got %h want 00", grant); end
        checks++; if (iic_sel !== 8'h02) begin failures++; $display("FAIL single_sel_hold: got %h want 02", iic_sel); end
        n = 0;
        while (iic_sel !== 8'hFF && n < 40) begin @(negedge clk); n++; end
        checks++; if (n !== GUARD) begin failures++; $display("FAIL single_guard: got %0d want %0d", n, GUARD); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int ch;
        int e;
        bit multi;
        bit ok;
        do_reset();
        for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            run_xfer(5, ch, multi, ok);
            e = pop_exp();
            checks++; if (!ok) begin failures++; $display("FAIL rr_timeout: xfer %0d got no completion want completion", i); end
            checks++; if (ch !== e) begin failures++; $display("FAIL rr_order: xfer %0d got ch %0d want %0d", i, ch, e); end
            checks++; if (multi) begin failures++; $display("FAIL rr_onehot: xfer %0d got multiple grants want one", i); end
        end
        req = 8'h00;
    endtask

    task automatic test_pointer_wrap();
        int ch;
        int e;
        bit multi;
        bit ok;
        do_reset();
        exp_q.push_back(5);
        req = 8'h20;
        run_xfer(3, ch, multi, ok);
        e = pop_exp();
        checks++; if (!ok || ch !== e) begin failures++; $display("FAIL wrap_first: got ch %0d ok %0d want %0d", ch, ok, e); end
        exp_q.push_back(0);
        exp_q.push_back(5);
        req = 8'h21;
        run_xfer(3, ch, multi, ok);
        e = pop_exp();
        checks++; if (!ok || ch !== e) begin failures++; $display("FAIL wrap_second: got ch %0d ok %0d want %0d", ch, ok, e); end
        run_xfer(3, ch, multi, ok);
        req = 8'h00;
        e = pop_exp();
        checks++; if (!ok || ch !== e) begin failures++; $display("FAIL wrap_third: got ch %0d ok %0d want %0d", ch, ok, e); end
    endtask

    task automatic test_stray_done();
        int n;
        int extra;
        do_reset();
        req = 8'h02;
        @(negedge clk);
        n = 0;
        while (xfer_start !== 1'b1 && n < 40) begin
            xfer_done = (n == 3);
            @(negedge clk);
            n++;
        end
        xfer_done = 1'b0;
        checks++; if (n !== SETTLE) begin failures++; $display("FAIL stray_settle: got %0d want %0d", n, SETTLE); end
        checks++; if (iic_sel !== 8'h01) begin failures++; $display("FAIL stray_sel: got %h want 01", iic_sel); end
        repeat (3) @(negedge clk);
        xfer_done = 1'b1;
        @(negedge clk);
        xfer_done = 1'b0;
        req = 8'h00;
        n = 0;
        extra = 0;
        while (iic_sel !== 8'hFF && n < 40) begin
            xfer_done = (n == 2);
            if (xfer_start) extra++;
            if (iic_sel !== 8'h01) extra++;
            @(negedge clk);
            n++;
        end
        xfer_done = 1'b0;
        checks++; if (n !== GUARD) begin failures++; $display("FAIL stray_guard: got %0d want %0d", n, GUARD); end
        repeat (30) begin
            if (xfer_start || busy) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL stray_extra: got %0d events want 0", extra); end
    endtask

    task automatic test_mid_reset();
        int n;
        int e;
        int ch;
        bit multi;
        bit ok;
        do_reset();
        exp_q.push_back(3);
        req = 8'h08;
        n = 0;
        while (xfer_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        e = pop_exp();
        checks++; if (onehot_idx(grant) !== e) begin failures++; $display("FAIL mrst_grant: got %0d want %0d", onehot_idx(grant), e); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h09;
        checks++; if (iic_sel !== 8'hFF) begin failures++; $display("FAIL mrst_sel: got %h want ff", iic_sel); end
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL mrst_grant_clr: got %h want 00", grant); end
        checks++; if ({busy, xfer_start, xfer_abort} !== 3'b000) begin failures++; $display("FAIL mrst_ctl: got %b want 000", {busy, xfer_start, xfer_abort}); end
        exp_q.push_back(0);
        run_xfer(4, ch, multi, ok);
        req = 8'h00;
        e = pop_exp();
        checks++; if (!ok || ch !== e) begin failures++; $display("FAIL mrst_next: got ch %0d ok %0d want %0d", ch, ok, e); end
    endtask

    task automatic test_timeout();
        int n;
        int e;
        do_reset();
        exp_q.push_back(6);
        req = 8'h40;
        n = 0;
        while (xfer_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        e = pop_exp();
        checks++; if (onehot_idx(grant) !== e) begin failures++; $display("FAIL to_grant: got %0d want %0d", onehot_idx(grant), e); end
        n = 0;
        while (xfer_abort !== 1'b1 && n < TO + 20) begin @(negedge clk); n++; end
`ifdef IIC_CHAN_SCHED_TIMEOUT_EN
        req = 8'h00;
        checks++; if (n !== TO + 1) begin failures++; $display("FAIL to_latency: got %0d want %0d", n, TO + 1); end
        checks++; if (timeout_ch !== 3'd6) begin failures++; $display("FAIL to_ch: got %0d want 6", timeout_ch); end
        checks++; if (grant !== 8'h00 || busy !== 1'b1) begin failures++; $display("FAIL to_guard: got grant %h busy %b want 00 1", grant, busy); end
        @(negedge clk);
        checks++; if (xfer_abort !== 1'b0) begin failures++; $display("FAIL to_pulse: got %b want 0", xfer_abort); end
        n = 1;
        while (iic_sel !== 8'hFF && n < 40) begin @(negedge clk); n++; end
        checks++; if (n !== GUARD) begin failures++; $display("FAIL to_release: got %0d want %0d", n, GUARD); end
        checks++; if (timeout_ch !== 3'd6) begin failures++; $display("FAIL to_sticky: got %0d want 6", timeout_ch); end
`else
        checks++; if (n !== TO + 20) begin failures++; $display("FAIL to_noabort: abort after %0d cycles want none", n); end
        checks++; if (busy !== 1'b1 || grant !== 8'h40) begin failures++; $display("FAIL to_wait: got busy %b grant %h want 1 40", busy, grant); end
        checks++; if (timeout_ch !== 3'd0) begin failures++; $display("FAIL to_tch: got %0d want 0", timeout_ch); end
        xfer_done = 1'b1;
        @(negedge clk);
        xfer_done = 1'b0;
        req = 8'h00;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        checks++; if (n !== GUARD) begin failures++; $display("FAIL to_done: got %0d want %0d", n, GUARD); end
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'h00;
        xfer_done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_stray_done();
        test_mid_reset();
        test_timeout();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
